mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit sitting between the EX/MEM pipeline register and the word-addressed data memory in the pipelined core.
- Converts the ALU byte address to a word address.
- Performs byte/halfword load selection with sign or zero extension.
- Implements SB/SH as a two-cycle read-modify-write, because the data memory has no byte enables. It stalls the pipeline for the first of those two cycles.

Parameters:
- DM_ADDRESS, 9: data-memory word-address width.
- DATA_W, 32: data word width. Only 32 is supported.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  load request from control unit (EX/MEM)
- MemWrite  in  1  store request from control unit (EX/MEM)
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  DATA_W  byte address (ALU result)
- store_data  in  DATA_W  rs2 value; data is in the low bits for SB/SH
- dm_MemRead  out  1  to data memory
- dm_MemWrite  out  1  to data memory
- dm_a  out  DM_ADDRESS  word address to data memory
- dm_wd  out  DATA_W  write data to data memory
- dm_rd  in  DATA_W  combinational read data from data memory
- load_data  out  DATA_W  aligned and extended load result, to MEM/WB
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- misalign  out  1  misaligned access; the access is suppressed

Behaviour:
- Word address: dm_a = addr[DM_ADDRESS+1:2] in state IDLE.
- Misalignment:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - When misaligned: misalign=1 (combinational), dm_MemRead=0, dm_MemWrite=0, load_data=0, stall=0, and the FSM stays in IDLE.
- FSM states: IDLE, RMW_WR. Encoding comes from the package. Reset state is IDLE.
- IDLE, load: dm_MemRead=1. load_data = dm_rd lane selected by addr[1:0], extended per funct3, same cycle. No stall.
- IDLE, SW (aligned): dm_MemWrite=1, dm_wd=store_data. Single cycle, no stall.
- IDLE, SB/SH (aligned):
  - Drive dm_MemRead=1 and stall=1.
  - At clk edge, register merge_q = dm_rd with the target byte/half lane replaced by store_data[7:0] or store_data[15:0].
  - Register addr_q = dm_a.
  - Next state RMW_WR.
- RMW_WR:
  - dm_MemWrite=1, dm_a=addr_q, dm_wd=merge_q, dm_MemRead=0, stall=0.
  - EX/MEM inputs (held by the stall) are ignored.
  - Next state IDLE unconditionally.
  - The memory write completes at the end of this cycle. The pipeline advances at the same edge.
- Merge is always registered and never combinational dm_rd -> dm_wd. This avoids a read-to-write comb path through memory.
- MemRead and MemWrite both high: treated as a store; the load is ignored.
- Other outputs at reset: stall=0, dm_MemWrite=0, misalign=0, dm_wd=0. load_data is not forced.
- Outputs while reset=1: dm_MemWrite=0, dm_MemRead=0, stall=0, misalign=0, and the next state is IDLE.
- Reset asserted in RMW_WR: the write is dropped (dm_MemWrite=0) and the FSM returns to IDLE.
- Unused funct3 (011, 110, 111): treated as W for misalign checking and access size.
- Address bits above DM_ADDRESS+1 are ignored, so addresses wrap modulo memory size.

Decomposition:
- Package mem_access_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - enum lsu_state_t {IDLE, RMW_WR}.
  - Function lane_merge(word, data, off, size).
- Sub-module load_align: combinational. Inputs dm_rd, addr[1:0], funct3. Output is the extended load_data. Shared with later uncached-peripheral path.

Test Plan:
- mem[4]=0x8899AABB preloaded; LB addr=0x13 -> dm_a=4, load_data=0xFFFFFF88. LBU same -> 0x00000088. LH addr=0x12 -> 0xFFFF8899. No stall.
- SW addr=0x20, data=0xDEADBEEF -> dm_MemWrite=1 and dm_a=8 in one cycle, stall=0; then mem[8]=0xDEADBEEF.
- mem[8]=0xDEADBEEF; SB addr=0x21, data=0x55:
  - Cycle 1: stall=1, dm_MemRead=1, dm_MemWrite=0.
  - Cycle 2: dm_MemWrite=1, dm_wd=0xDEAD55EF, stall=0.
  - Result: mem[8]=0xDEAD55EF.
- SH addr=0x22, data=0x1234 on mem[8]=0xDEAD55EF -> after 2 cycles mem[8]=0x123455EF; the next LW of 0x20 returns 0x123455EF.
- LW addr=0x22 -> misalign=1, dm_MemRead=0, load_data=0. SH addr=0x23 -> misalign=1, no write, stall=0.
- SB issued, reset=1 during RMW_WR -> dm_MemWrite=0, memory unchanged, state IDLE, stall=0 on the following cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
package mem_access_pkg;

    localparam int unsigned DataW = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } access_size_t;

    // The unused encodings 011/110/111 fall through to word accesses.
    function automatic access_size_t access_size(input logic [2:0] funct3);
        access_size_t size;
        case (funct3[1:0])
            2'b00:   size = SZ_B;
            2'b01:   size = SZ_H;
            default: size = SZ_W;
        endcase
        return size;
    endfunction

    function automatic logic [DataW-1:0] lane_merge(input logic [DataW-1:0] word,
                                                    input logic [DataW-1:0] data,
                                                    input logic [1:0]       off,
                                                    input access_size_t     size);
        logic [DataW-1:0] merged;
        merged = word;
        case (size)
            SZ_B: merged[{off, 3'b000} +: 8] = data[7:0];
            SZ_H: begin
                if (off[1]) merged[31:16] = data[15:0];
                else        merged[15:0]  = data[15:0];
            end
            default: merged = data;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed data-memory port between the load/store unit and the memory.
interface mem_access_unit_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) ();

    logic                  dm_MemRead;
    logic                  dm_MemWrite;
    logic [DM_ADDRESS-1:0] dm_a;
    logic [DATA_W-1:0]     dm_wd;
    logic [DATA_W-1:0]     dm_rd;

    modport master (
        output dm_MemRead,
        output dm_MemWrite,
        output dm_a,
        output dm_wd,
        input  dm_rd
    );

    modport slave (
        input  dm_MemRead,
        input  dm_MemWrite,
        input  dm_a,
        input  dm_wd,
        output dm_rd
    );

endinterface

// File: rtl/load_align.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it.
module load_align
    import mem_access_pkg::*;
(
    input  logic [DataW-1:0] dm_rd_i,
    input  logic [1:0]       off_i,
    input  logic [2:0]       funct3_i,
    output logic [DataW-1:0] load_data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_ext;

    always_comb begin
        byte_lane = dm_rd_i[{off_i, 3'b000} +: 8];
        half_lane = off_i[1] ? dm_rd_i[31:16] : dm_rd_i[15:0];
        sign_ext  = ~funct3_i[2];
        case (access_size(funct3_i))
            SZ_B:    load_data_o = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_H:    load_data_o = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_data_o = dm_rd_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: word addressing, load alignment, and SB/SH as a two-cycle
// read-modify-write because the data memory has no byte enables.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [2:0]         funct3,
    input  logic [DATA_W-1:0]  addr,
    input  logic [DATA_W-1:0]  store_data,
    mem_access_unit_if.master  dm,
    output logic [DATA_W-1:0]  load_data,
    output logic               stall,
    output logic               misalign
);

    lsu_state_t            state_q, state_d;
    logic [DATA_W-1:0]     merge_q, merge_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;

    logic [DM_ADDRESS-1:0] word_a;
    logic [DATA_W-1:0]     aligned;
    access_size_t          size;
    logic                  bad_align;
    logic                  unused_addr_hi;

    // Upper address bits are dropped so accesses wrap modulo memory size.
    assign word_a         = addr[DM_ADDRESS+1:2];
    assign unused_addr_hi = ^addr[DATA_W-1:DM_ADDRESS+2];

    load_align u_load_align (
        .dm_rd_i     (dm.dm_rd),
        .off_i       (addr[1:0]),
        .funct3_i    (funct3),
        .load_data_o (aligned)
    );

    always_comb begin
        size      = access_size(funct3);
        bad_align = ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00));

        state_d        = state_q;
        merge_d        = merge_q;
        addr_d         = addr_q;
        dm.dm_MemRead  = 1'b0;
        dm.dm_MemWrite = 1'b0;
        dm.dm_a        = word_a;
        dm.dm_wd       = '0;
        load_data      = aligned;
        stall          = 1'b0;
        misalign       = 1'b0;

        if (reset) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((MemRead || MemWrite) && bad_align) begin
                        misalign  = 1'b1;
                        load_data = '0;
                    end else if (MemWrite) begin
                        if (size == SZ_W) begin
                            dm.dm_MemWrite = 1'b1;
                            dm.dm_wd       = store_data;
                        end else begin
                            // Read phase: capture the merged word, write it next cycle.
                            dm.dm_MemRead = 1'b1;
                            stall         = 1'b1;
                            merge_d       = lane_merge(dm.dm_rd, store_data, addr[1:0], size);
                            addr_d        = word_a;
                            state_d       = RMW_WR;
                        end
                    end else if (MemRead) begin
                        dm.dm_MemRead = 1'b1;
                    end
                end
                RMW_WR: begin
                    dm.dm_MemWrite = 1'b1;
                    dm.dm_a        = addr_q;
                    dm.dm_wd       = merge_q;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        merge_q <= merge_d;
        addr_q  <= addr_d;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, RMW/reset sequences, random ops vs a byte-level model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, misalign;

    logic [31:0] mem [512];
    logic        tb_we;
    logic [8:0]  tb_wa;
    logic [31:0] tb_wd;

    int n_pass  = 0;
    int n_total = 0;

    mem_access_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) dm_if ();

    mem_access_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .dm         (dm_if),
        .load_data  (load_data),
        .stall      (stall),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    assign dm_if.dm_rd = mem[dm_if.dm_a];

    always @(posedge clk) begin
        if (dm_if.dm_MemWrite) mem[dm_if.dm_a] <= dm_if.dm_wd;
        else if (tb_we)        mem[tb_wa] <= tb_wd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        tb_we = 1'b1;
        tb_wa = 9'(idx);
        tb_wd = val;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        MemRead = mr; MemWrite = mw; funct3 = f3; addr = a; store_data = sd;
    endtask

    typedef struct {
        string       name;
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] a, sd;
        logic        e_mis, e_dmr, e_dmw;
        logic [8:0]  e_dma;
        logic        chk_ld;
        logic [31:0] e_ld;
    } vec_t;

    function automatic vec_t mk(input string n, input logic mr, input logic mw,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                                input logic mis, input logic dmr, input logic dmw,
                                input logic [8:0] dma, input logic chk, input logic [31:0] ld);
        vec_t v;
        v.name = n; v.mr = mr; v.mw = mw; v.f3 = f3; v.a = a; v.sd = sd;
        v.e_mis = mis; v.e_dmr = dmr; v.e_dmw = dmw; v.e_dma = dma; v.chk_ld = chk; v.e_ld = ld;
        return v;
    endfunction

    vec_t        vecs [13];
    logic [31:0] ref_mem [32];
    logic [2:0]  f3_pool [8];

    initial begin
        reset = 1'b1; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        drive(1'b0, 1'b1, F3_W, 32'h22, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_dmw", {31'b0, dm_if.dm_MemWrite}, 32'd0);
        check("rst_dmr", {31'b0, dm_if.dm_MemRead}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_wd", dm_if.dm_wd, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        preload(4, 32'h8899_AABB);
        reset = 1'b0;
        preload(8, 32'h0);

        vecs[0]  = mk("lb_13",    1, 0, F3_B,   32'h13,  0, 0, 1, 0, 4, 1, 32'hFFFF_FF88);
        vecs[1]  = mk("lbu_13",   1, 0, F3_BU,  32'h13,  0, 0, 1, 0, 4, 1, 32'h0000_0088);
        vecs[2]  = mk("lh_12",    1, 0, F3_H,   32'h12,  0, 0, 1, 0, 4, 1, 32'hFFFF_8899);
        vecs[3]  = mk("lhu_10",   1, 0, F3_HU,  32'h10,  0, 0, 1, 0, 4, 1, 32'h0000_AABB);
        vecs[4]  = mk("lb_10",    1, 0, F3_B,   32'h10,  0, 0, 1, 0, 4, 1, 32'hFFFF_FFBB);
        vecs[5]  = mk("lbu_11",   1, 0, F3_BU,  32'h11,  0, 0, 1, 0, 4, 1, 32'h0000_00AA);
        vecs[6]  = mk("lw_wrap",  1, 0, F3_W,   32'h810, 0, 0, 1, 0, 4, 1, 32'h8899_AABB);
        vecs[7]  = mk("f3_110",   1, 0, 3'b110, 32'h10,  0, 0, 1, 0, 4, 1, 32'h8899_AABB);
        vecs[8]  = mk("lw_mis",   1, 0, F3_W,   32'h22,  0, 1, 0, 0, 8, 1, 32'h0);
        vecs[9]  = mk("sh_mis",   0, 1, F3_H,   32'h23,  32'h1234, 1, 0, 0, 8, 1, 32'h0);
        vecs[10] = mk("f3_011",   1, 0, 3'b011, 32'h11,  0, 1, 0, 0, 4, 1, 32'h0);
        vecs[11] = mk("sw_20",    0, 1, F3_W,   32'h20,  32'hDEAD_BEEF, 0, 0, 1, 8, 0, 32'h0);
        vecs[12] = mk("rdwr_sw",  1, 1, F3_W,   32'h30,  32'hCAFE_F00D, 0, 0, 1, 12, 0, 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].a, vecs[i].sd);
            @(negedge clk);
            check({vecs[i].name, "_mis"}, {31'b0, misalign}, {31'b0, vecs[i].e_mis});
            check({vecs[i].name, "_dmr"}, {31'b0, dm_if.dm_MemRead}, {31'b0, vecs[i].e_dmr});
            check({vecs[i].name, "_dmw"}, {31'b0, dm_if.dm_MemWrite}, {31'b0, vecs[i].e_dmw});
            check({vecs[i].name, "_dma"}, {23'b0, dm_if.dm_a}, {23'b0, vecs[i].e_dma});
            check({vecs[i].name, "_stall"}, {31'b0, stall}, 32'd0);
            if (vecs[i].chk_ld) check({vecs[i].name, "_ld"}, load_data, vecs[i].e_ld);
            if (vecs[i].e_dmw) check({vecs[i].name, "_wd"}, dm_if.dm_wd, vecs[i].sd);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        check("mem8_sw", mem[8], 32'hDEAD_BEEF);
        check("mem12_rdwr", mem[12], 32'hCAFE_F00D);
        @(posedge clk); #1;

        // SB then SH read-modify-write on mem[8]
        drive(1'b0, 1'b1, F3_B, 32'h21, 32'h0000_0055);
        @(negedge clk);
        check("sb_c1_stall", {31'b0, stall}, 32'd1);
        check("sb_c1_dmr", {31'b0, dm_if.dm_MemRead}, 32'd1);
        check("sb_c1_dmw", {31'b0, dm_if.dm_MemWrite}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("sb_c2_dmw", {31'b0, dm_if.dm_MemWrite}, 32'd1);
        check("sb_c2_wd", dm_if.dm_wd, 32'hDEAD_55EF);
        check("sb_c2_dma", {23'b0, dm_if.dm_a}, 32'd8);
        check("sb_c2_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, F3_H, 32'h22, 32'h0000_1234);
        @(negedge clk);
        check("sb_mem8", mem[8], 32'hDEAD_55EF);
        check("sh_c1_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
        @(negedge clk);
        check("sh_mem8", mem[8], 32'h1234_55EF);
        check("lw_after_sh", load_data, 32'h1234_55EF);
        check("lw_after_sh_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;

        // Reset during the write phase drops the write
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        preload(16, 32'h1122_3344);
        drive(1'b0, 1'b1, F3_B, 32'h40, 32'h0000_00AA);
        @(negedge clk);
        check("rst_rmw_c1_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_rmw_dmw", {31'b0, dm_if.dm_MemWrite}, 32'd0);
        check("rst_rmw_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, F3_W, 32'h40, 32'h0);
        @(negedge clk);
        check("rst_rmw_after_stall", {31'b0, stall}, 32'd0);
        check("rst_rmw_after_dmw", {31'b0, dm_if.dm_MemWrite}, 32'd0);
        check("rst_rmw_after_dmr", {31'b0, dm_if.dm_MemRead}, 32'd1);
        check("rst_rmw_mem16", mem[16], 32'h1122_3344);
        check("rst_rmw_ld", load_data, 32'h1122_3344);
        @(posedge clk); #1;

        // Random ops against a byte-level memory model
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = $urandom;
            preload(i, ref_mem[i]);
        end
        f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int t = 0; t < 200; t++) begin
            logic        mr, mw, mis;
            logic [2:0]  f3;
            logic [31:0] a, sd, raw;
            int          n, w, b;
            mr = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            if (!mr && !mw) mr = 1'b1;
            f3 = f3_pool[$urandom_range(0, 7)];
            a  = $urandom & 32'hFFFF_F07F;
            sd = $urandom;
            n  = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
            mis = (a % n) != 0;
            w  = int'((a >> 2) % 32);
            b  = int'(a % 4);
            drive(mr, mw, f3, a, sd);
            @(negedge clk);
            check("rnd_mis", {31'b0, misalign}, {31'b0, mis});
            if (mis) begin
                check("rnd_mis_ld", load_data, 32'h0);
                check("rnd_mis_dmw", {31'b0, dm_if.dm_MemWrite}, 32'd0);
                @(posedge clk); #1;
            end else if (mw) begin
                for (int k = 0; k < n; k++) ref_mem[w][8*(b+k) +: 8] = sd[8*k +: 8];
                check("rnd_st_stall", {31'b0, stall}, {31'b0, n != 4});
                @(posedge clk); #1;
                if (n != 4) begin
                    @(negedge clk);
                    check("rnd_rmw_wd", dm_if.dm_wd, ref_mem[w]);
                    @(posedge clk); #1;
                end
            end else begin
                raw = ref_mem[w] >> (8 * b);
                if (n == 1) begin
                    raw = raw & 32'hFF;
                    if (f3 == 3'b000 && raw[7]) raw = raw | 32'hFFFF_FF00;
                end else if (n == 2) begin
                    raw = raw & 32'hFFFF;
                    if (f3 == 3'b001 && raw[15]) raw = raw | 32'hFFFF_0000;
                end
                check("rnd_ld", load_data, raw);
                @(posedge clk); #1;
            end
        end
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 32; i++) check("rnd_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
